// File: rtl/composite_timing_gen.sv
// composite_timing_gen
//   Horizontal/vertical timing sequencer for a 262-line progressive NTSC
//   raster on the composite/S-video path. It drives the modulator's sync,
//   burst and active qualifiers and gives the fetch logic pixel coordinates.
//
// Ports
//   clk          in   pixel/system clock
//   rst          in   synchronous, active-high reset
//   enable       in   run raster; low clears the counters and idles the outputs
//   sync_n       out  composite sync, active low
//   color_burst  out  burst window
//   active       out  picture window
//   pix_x[10:0]  out  active-area column, 0 outside the picture window
//   pix_y[7:0]   out  active-area line, 0 outside the picture window
//   line_start   out  one-cycle pulse for h_cnt==0
//   frame_start  out  one-cycle pulse for h_cnt==0 and v_cnt==0
//
// Every output is registered from the decode of the (h_cnt, v_cnt) pair
// present on the previous clock, so the pins lag the counters by one cycle.
// Handshake: none. The block free-runs while enable=1 and has no valid/ready
// interface; downstream consumers qualify data with active.
module composite_timing_gen #(
  parameter int unsigned H_TOTAL        = 1589,
  parameter int unsigned H_HALF         = 794,
  parameter int unsigned H_SYNC         = 118,
  parameter int unsigned H_EQ           = 59,
  parameter int unsigned BURST_START    = 133,
  parameter int unsigned BURST_LEN      = 56,
  parameter int unsigned H_ACTIVE_START = 240,
  parameter int unsigned H_ACTIVE_LEN   = 1280,
  parameter int unsigned V_TOTAL        = 262,
  parameter int unsigned V_ACTIVE_START = 21,
  parameter int unsigned V_ACTIVE_LEN   = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        sync_n,
  output logic        color_burst,
  output logic        active,
  output logic [10:0] pix_x,
  output logic [7:0]  pix_y,
  output logic        line_start,
  output logic        frame_start
);

  // Line type of the line currently being scanned.
  typedef enum logic [2:0] {
    L_EQ_PRE  = 3'd0,
    L_VSYNC   = 3'd1,
    L_EQ_POST = 3'd2,
    L_BLANK   = 3'd3,
    L_ACTIVE  = 3'd4
  } line_state_t;

  // Horizontal and vertical thresholds, sized to the counter widths.
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_EQ_END     = 11'(H_EQ);
  localparam logic [10:0] H_HALF_C     = 11'(H_HALF);
  localparam logic [10:0] H_HALF_EQ    = 11'(H_HALF + H_EQ);
  localparam logic [10:0] H_VS_END1    = 11'(H_HALF - H_SYNC);
  localparam logic [10:0] H_VS_END2    = 11'(H_TOTAL - H_SYNC);
  localparam logic [10:0] H_SYNC_END   = 11'(H_SYNC);
  localparam logic [10:0] H_BURST_S    = 11'(BURST_START);
  localparam logic [10:0] H_BURST_E    = 11'(BURST_START + BURST_LEN);
  localparam logic [10:0] H_ACT_S      = 11'(H_ACTIVE_START);
  localparam logic [10:0] H_ACT_E      = 11'(H_ACTIVE_START + H_ACTIVE_LEN);
  localparam logic [8:0]  V_LAST       = 9'(V_TOTAL - 1);
  localparam logic [8:0]  V_ACT_S      = 9'(V_ACTIVE_START);
  localparam logic [8:0]  V_ACT_E      = 9'(V_ACTIVE_START + V_ACTIVE_LEN);

  logic [10:0] h_cnt;
  logic [8:0]  v_cnt;
  line_state_t state;
  line_state_t state_next;

  logic        h_wrap;
  logic [10:0] h_next;
  logic [8:0]  v_next;

  logic        sync_low_d;
  logic        burst_d;
  logic        active_d;
  logic [10:0] pix_x_d;
  logic [7:0]  pix_y_d;
  logic        line_start_d;
  logic        frame_start_d;

  function automatic line_state_t line_type(input logic [8:0] v);
    line_state_t t;
    if (v < 9'd3)                      t = L_EQ_PRE;
    else if (v < 9'd6)                 t = L_VSYNC;
    else if (v < 9'd9)                 t = L_EQ_POST;
    else if (v >= V_ACT_S && v < V_ACT_E) t = L_ACTIVE;
    else                               t = L_BLANK;
    return t;
  endfunction

  // Line-type state register. It only moves on the h_cnt wrap, so it always
  // matches the decode of v_cnt; idle and reset park it at line 0's type.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state <= L_EQ_PRE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode for the current (h_cnt, v_cnt).
  always_comb begin
    h_wrap        = (h_cnt == H_LAST);
    h_next        = h_wrap ? 11'd0 : h_cnt + 11'd1;
    v_next        = v_cnt;
    state_next    = state;
    sync_low_d    = 1'b0;
    burst_d       = 1'b0;
    active_d      = 1'b0;
    pix_x_d       = 11'd0;
    pix_y_d       = 8'd0;
    line_start_d  = (h_cnt == 11'd0);
    frame_start_d = (h_cnt == 11'd0) && (v_cnt == 9'd0);

    if (h_wrap) begin
      v_next     = (v_cnt == V_LAST) ? 9'd0 : v_cnt + 9'd1;
      state_next = line_type(v_next);
    end

    case (state)
      L_EQ_PRE, L_EQ_POST: begin
        sync_low_d = (h_cnt < H_EQ_END) ||
                     (h_cnt >= H_HALF_C && h_cnt < H_HALF_EQ);
      end
      L_VSYNC: begin
        // Broad pulses serrated at the line start and the half-line point.
        sync_low_d = (h_cnt < H_VS_END1) ||
                     (h_cnt >= H_HALF_C && h_cnt < H_VS_END2);
      end
      L_BLANK: begin
        sync_low_d = (h_cnt < H_SYNC_END);
        burst_d    = (h_cnt >= H_BURST_S) && (h_cnt < H_BURST_E);
      end
      L_ACTIVE: begin
        sync_low_d = (h_cnt < H_SYNC_END);
        burst_d    = (h_cnt >= H_BURST_S) && (h_cnt < H_BURST_E);
        active_d   = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
      end
      default: begin
        sync_low_d = 1'b0;
      end
    endcase

    if (active_d) begin
      pix_x_d = h_cnt - H_ACT_S;
      pix_y_d = 8'(v_cnt - V_ACT_S);
    end
  end

  // Counters and registered outputs. enable=0 behaves like a soft reset so
  // the raster restarts at (0,0) and emits frame_start on re-enable.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      h_cnt       <= 11'd0;
      v_cnt       <= 9'd0;
      sync_n      <= 1'b1;
      color_burst <= 1'b0;
      active      <= 1'b0;
      pix_x       <= 11'd0;
      pix_y       <= 8'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      sync_n      <= ~sync_low_d;
      color_burst <= burst_d;
      active      <= active_d;
      pix_x       <= pix_x_d;
      pix_y       <= pix_y_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end

endmodule
